// File: rtl/fila_pkg.sv
// Shared types and defaults for the stop-queue scheduler (fila_scheduler).
package fila_pkg;

  localparam int DEPTH_DEF = 16;
  localparam int AW_DEF    = 4;
  localparam int FW        = 2;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    CLEAR       = 3'd1,
    POP         = 3'd2,
    SCAN        = 3'd3,
    FIT         = 3'd4,
    APPEND_ORIG = 3'd5,
    APPEND_DEST = 3'd6
  } state_e;

endpackage

// File: rtl/fila_between_cmp.sv
// Floor comparator: strict "floor lies between prev and cur" plus equality with either stop.
module fila_between_cmp
  import fila_pkg::*;
(
  input  logic [FW-1:0] prev_i,
  input  logic [FW-1:0] cur_i,
  input  logic [FW-1:0] floor_i,
  output logic          hit_o,
  output logic          eq_o
);

  logic [FW-1:0] lo;
  logic [FW-1:0] hi;

  always_comb begin
    lo    = (prev_i < cur_i) ? prev_i : cur_i;
    hi    = (prev_i < cur_i) ? cur_i  : prev_i;
    hit_o = (lo < floor_i) && (floor_i < hi);
    eq_o  = (prev_i == floor_i) || (cur_i == floor_i);
  end

endmodule

// File: rtl/fila_scheduler.sv
// Stop-queue sequencer: serves clear/pop and places origin/destination stops in the stop RAM.
// Optional macro FILA_DEDUP_EN: skip the origin stop when that floor is already queued.
module fila_scheduler
  import fila_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_tipo,
  input  logic [1:0]    req_origem,
  input  logic [1:0]    req_destino,
  input  logic          pop,
  input  logic          clear_all,
  output logic          busy,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          full,
  output logic          ram_weT,
  output logic          ram_shift,
  output logic          ram_fit,
  output logic          ram_clear,
  output logic [AW-1:0] ram_addr_sec,
  output logic [AW-1:0] ram_addr_sec_ant,
  output logic          ram_in_eh_origem,
  output logic [1:0]    ram_in_tipo,
  output logic [1:0]    ram_in_origem,
  output logic [1:0]    ram_in_destino,
  input  logic [1:0]    ram_saida_sec,
  input  logic [1:0]    ram_saida_sec_ant,
  output logic [2:0]    dbg_state
);

  localparam logic [AW:0] REQ_MAX  = (AW+1)'(DEPTH - 2);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_C    = (AW+1)'(1);

  state_e        state_q;
  logic [AW:0]   count_q;
  logic [AW-1:0] k_q;
  logic [AW-1:0] addr_sec_q;
  logic [AW-1:0] addr_ant_q;
  logic          pend_q;
  logic          wet_q;
  logic          shift_q;
  logic          fit_q;
  logic          clr_q;
  logic          eh_q;
  logic [FW-1:0] tipo_q;
  logic [FW-1:0] orig_q;
  logic [FW-1:0] dest_q;

  logic [AW:0]   k_ext;
  logic          cur_valid;
  logic [FW-1:0] cur_eff;
  logic          cmp_hit;
  logic          cmp_eq;
  logic          scan_hit;
  logic          scan_last;

  // Handshake: a request transfers on a rising edge with req_valid && req_ready; ready is only
  // offered in IDLE with two free entries and no clear/pop (new or pending) competing for that cycle.
  assign req_ready = reset && (state_q == IDLE) && (count_q <= REQ_MAX)
                     && !clear_all && !pop && !pend_q;

  assign busy             = (state_q != IDLE);
  assign count            = count_q;
  assign empty            = (count_q == '0);
  assign full             = (count_q == FULL_CNT);
  assign ram_weT          = wet_q;
  assign ram_shift        = shift_q;
  assign ram_fit          = fit_q;
  assign ram_clear        = clr_q;
  assign ram_addr_sec     = addr_sec_q;
  assign ram_addr_sec_ant = addr_ant_q;
  assign ram_in_eh_origem = eh_q;
  assign ram_in_tipo      = tipo_q;
  assign ram_in_origem    = orig_q;
  assign ram_in_destino   = dest_q;
  assign dbg_state        = state_q;

  // With a single valid stop the comparator sees (prev, prev): no between-hit, only equality.
  assign k_ext     = {1'b0, k_q};
  assign cur_valid = (k_ext < count_q);
  assign cur_eff   = cur_valid ? ram_saida_sec : ram_saida_sec_ant;
  assign scan_hit  = cur_valid && cmp_hit;
  assign scan_last = ((k_ext + ONE_C) >= count_q);

  fila_between_cmp u_cmp (
    .prev_i  (ram_saida_sec_ant),
    .cur_i   (cur_eff),
    .floor_i (orig_q),
    .hit_o   (cmp_hit),
    .eq_o    (cmp_eq)
  );

`ifdef FILA_DEDUP_EN
  logic scan_dup;
  assign scan_dup = (count_q != '0) && cmp_eq;
`else
  logic unused_eq;
  assign unused_eq = cmp_eq;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      k_q        <= '0;
      addr_sec_q <= '0;
      addr_ant_q <= '0;
      pend_q     <= 1'b0;
      wet_q      <= 1'b0;
      shift_q    <= 1'b0;
      fit_q      <= 1'b0;
      clr_q      <= 1'b0;
      eh_q       <= 1'b0;
      tipo_q     <= '0;
      orig_q     <= '0;
      dest_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (clear_all) begin
            state_q <= CLEAR;
            clr_q   <= 1'b1;
            pend_q  <= 1'b0;
          end else if (pop || pend_q) begin
            state_q <= POP;
            shift_q <= (count_q != '0);
            pend_q  <= 1'b0;
          end else if (req_valid && req_ready) begin
            state_q    <= SCAN;
            k_q        <= AW'(1);
            addr_ant_q <= '0;
            addr_sec_q <= AW'(1);
            eh_q       <= 1'b1;
            tipo_q     <= req_tipo;
            orig_q     <= req_origem;
            dest_q     <= req_destino;
          end
        end
        CLEAR: begin
          clr_q   <= 1'b0;
          count_q <= '0;
          state_q <= IDLE;
        end
        POP: begin
          shift_q <= 1'b0;
          if (shift_q) count_q <= count_q - ONE_C;
          state_q <= IDLE;
        end
        SCAN: begin
`ifdef FILA_DEDUP_EN
          if (scan_dup) begin
            wet_q   <= 1'b1;
            eh_q    <= 1'b0;
            state_q <= APPEND_DEST;
          end else
`endif
          if (scan_hit) begin
            fit_q   <= 1'b1;
            state_q <= FIT;
          end else if (scan_last) begin
            wet_q   <= 1'b1;
            state_q <= APPEND_ORIG;
          end else begin
            k_q        <= k_q + AW'(1);
            addr_ant_q <= k_q;
            addr_sec_q <= k_q + AW'(1);
          end
        end
        FIT: begin
          fit_q   <= 1'b0;
          count_q <= count_q + ONE_C;
          wet_q   <= 1'b1;
          eh_q    <= 1'b0;
          state_q <= APPEND_DEST;
        end
        APPEND_ORIG: begin
          count_q <= count_q + ONE_C;
          eh_q    <= 1'b0;
          state_q <= APPEND_DEST;
        end
        APPEND_DEST: begin
          wet_q   <= 1'b0;
          count_q <= count_q + ONE_C;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      if (pop && (state_q != IDLE)) pend_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fila_scheduler.sv
// Bench for fila_scheduler: stop-RAM stand-in, queue-level stop-order model, directed and random scenarios.
`timescale 1ns/1ps
module tb_fila_scheduler;
  import fila_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_tipo = '0;
  logic [1:0]    req_origem = '0;
  logic [1:0]    req_destino = '0;
  logic          pop = 1'b0;
  logic          clear_all = 1'b0;
  logic          busy;
  logic [AW:0]   count;
  logic          empty;
  logic          full;
  logic          ram_weT, ram_shift, ram_fit, ram_clear;
  logic [AW-1:0] ram_addr_sec, ram_addr_sec_ant;
  logic          ram_in_eh_origem;
  logic [1:0]    ram_in_tipo, ram_in_origem, ram_in_destino;
  logic [1:0]    ram_saida_sec, ram_saida_sec_ant;
  logic [2:0]    dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [1:0] exp_q[$];

  fila_scheduler #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_tipo         (req_tipo),
    .req_origem       (req_origem),
    .req_destino      (req_destino),
    .pop              (pop),
    .clear_all        (clear_all),
    .busy             (busy),
    .count            (count),
    .empty            (empty),
    .full             (full),
    .ram_weT          (ram_weT),
    .ram_shift        (ram_shift),
    .ram_fit          (ram_fit),
    .ram_clear        (ram_clear),
    .ram_addr_sec     (ram_addr_sec),
    .ram_addr_sec_ant (ram_addr_sec_ant),
    .ram_in_eh_origem (ram_in_eh_origem),
    .ram_in_tipo      (ram_in_tipo),
    .ram_in_origem    (ram_in_origem),
    .ram_in_destino   (ram_in_destino),
    .ram_saida_sec    (ram_saida_sec),
    .ram_saida_sec_ant(ram_saida_sec_ant),
    .dbg_state        (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stop-RAM stand-in: stores the floor of each stop, reacting to the strobes mid-cycle.
  logic [1:0]    ram_mem [DEPTH];
  int            ram_n = 0;
  int            cnt_wet = 0, cnt_fit = 0, cnt_shift = 0, cnt_clr = 0, excl_err = 0;
  logic [7:0]    eh_hist = '0;
  logic [AW-1:0] fit_addr = '0;
  logic [1:0]    wet_tipo = '0;

  assign ram_saida_sec     = ram_mem[ram_addr_sec];
  assign ram_saida_sec_ant = ram_mem[ram_addr_sec_ant];

  always @(negedge clk) begin
    if ((int'(ram_weT) + int'(ram_fit) + int'(ram_shift) + int'(ram_clear)) > 1) excl_err <= excl_err + 1;
    if (ram_clear) begin
      cnt_clr <= cnt_clr + 1;
      ram_n   <= 0;
    end
    if (ram_shift) begin
      cnt_shift <= cnt_shift + 1;
      for (int i = 0; i < DEPTH - 1; i++) ram_mem[4'(i)] <= ram_mem[4'(i + 1)];
      if (ram_n > 0) ram_n <= ram_n - 1;
    end
    if (ram_fit) begin
      cnt_fit  <= cnt_fit + 1;
      fit_addr <= ram_addr_sec;
      for (int i = DEPTH - 1; i > int'(ram_addr_sec); i--) ram_mem[4'(i)] <= ram_mem[4'(i - 1)];
      ram_mem[ram_addr_sec] <= ram_in_origem;
      ram_n <= ram_n + 1;
    end
    if (ram_weT) begin
      cnt_wet  <= cnt_wet + 1;
      eh_hist  <= {eh_hist[6:0], ram_in_eh_origem};
      wet_tipo <= ram_in_tipo;
      if (ram_n < DEPTH) begin
        ram_mem[4'(ram_n)] <= ram_in_eh_origem ? ram_in_origem : ram_in_destino;
        ram_n <= ram_n + 1;
      end
    end
  end

  function automatic bit between(input logic [1:0] a, input logic [1:0] b, input logic [1:0] f);
    return ((a < f) && (f < b)) || ((b < f) && (f < a));
  endfunction

  function automatic bit ram_matches();
    if (ram_n != exp_q.size()) return 1'b0;
    foreach (exp_q[i]) if (ram_mem[4'(i)] !== exp_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  // driver tasks
  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      if (req_ready === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %0b exp 0", req_ready); end
    n_tests++;
    if (count !== '0 || busy !== 1'b0 || dbg_state !== IDLE) begin
      n_fail++; $display("FAIL reset_state: count %0d busy %0b state %0d exp 0/0/0", count, busy, dbg_state);
    end
    n_tests++;
    if ({ram_weT, ram_shift, ram_fit, ram_clear} !== 4'b0) begin
      n_fail++; $display("FAIL reset_strobes: got %b exp 0000", {ram_weT, ram_shift, ram_fit, ram_clear});
    end
    n_tests++;
    if ({ram_addr_sec, ram_addr_sec_ant, ram_in_eh_origem, ram_in_tipo, ram_in_origem, ram_in_destino} !== '0) begin
      n_fail++; $display("FAIL reset_fields: addr %0d/%0d fields %b%b%b%b exp all 0", ram_addr_sec,
                         ram_addr_sec_ant, ram_in_eh_origem, ram_in_tipo, ram_in_origem, ram_in_destino);
    end
    reset = 1'b1;
    @(negedge clk);
    n_tests++;
    if (empty !== 1'b1 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL post_reset: empty %0b ready %0b exp 1/1", empty, req_ready);
    end
  endtask

  task automatic test_clear(input string name);
    int c0;
    c0 = cnt_clr;
    @(negedge clk); clear_all = 1'b1;
    @(negedge clk); clear_all = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    n_tests++;
    if (cnt_clr - c0 != 1) begin n_fail++; $display("FAIL %s clear_pulses: got %0d exp 1", name, cnt_clr - c0); end
    n_tests++;
    if (count !== '0 || empty !== 1'b1) begin
      n_fail++; $display("FAIL %s clear_count: count %0d empty %0b exp 0/1", name, count, empty);
    end
  endtask

  task automatic test_pop(input string name);
    int s0, exp_sh;
    s0 = cnt_shift;
    exp_sh = (exp_q.size() > 0) ? 1 : 0;
    if (exp_sh == 1) void'(exp_q.pop_front());
    @(negedge clk); pop = 1'b1;
    @(negedge clk); pop = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (cnt_shift - s0 != exp_sh) begin n_fail++; $display("FAIL %s shift_pulses: got %0d exp %0d", name, cnt_shift - s0, exp_sh); end
    n_tests++;
    if (count !== (AW+1)'(exp_q.size())) begin n_fail++; $display("FAIL %s pop_count: got %0d exp %0d", name, count, exp_q.size()); end
    n_tests++;
    if (!ram_matches()) begin n_fail++; $display("FAIL %s pop_ram: ram_n %0d exp %0d entries", name, ram_n, exp_q.size()); end
  endtask

  task automatic test_request(input logic [1:0] t, input logic [1:0] o, input logic [1:0] d,
                              input bit pop_late, input string name);
    int n, ins, lat, exp_busy, exp_wet, exp_fit, w0, f0, s0, cycles;
    bit dup, ok;
    n = exp_q.size();
    ins = -1; dup = 1'b0;
    lat = (n < 2) ? 1 : n - 1;
    for (int i = 1; i < n && ins < 0 && !dup; i++) begin
`ifdef FILA_DEDUP_EN
      if (exp_q[i-1] == o || exp_q[i] == o) begin dup = 1'b1; lat = i; end else
`endif
      if (between(exp_q[i-1], exp_q[i], o)) begin ins = i; lat = i; end
    end
`ifdef FILA_DEDUP_EN
    if (n == 1 && exp_q[0] == o) dup = 1'b1;
`endif
    exp_busy = dup ? lat + 1 : lat + 2;
    exp_wet  = (dup || ins >= 0) ? 1 : 2;
    exp_fit  = (ins >= 0) ? 1 : 0;
    if (!dup) begin
      if (ins >= 0) exp_q.insert(ins, o); else exp_q.push_back(o);
    end
    exp_q.push_back(d);

    wait_ready(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL %s ready_timeout: req_ready %0b exp 1", name, req_ready); return; end
    w0 = cnt_wet; f0 = cnt_fit; s0 = cnt_shift;
    req_valid = 1'b1; req_tipo = t; req_origem = o; req_destino = d;
    @(negedge clk);
    req_valid = 1'b0;
    cycles = 0;
    while (busy === 1'b1 && cycles < 50) begin
      cycles++;
      if (pop_late && cycles == exp_busy) pop = 1'b1;
      @(negedge clk);
      pop = 1'b0;
    end

    n_tests++;
    if (cycles != exp_busy) begin n_fail++; $display("FAIL %s busy_cycles: got %0d exp %0d", name, cycles, exp_busy); end
    n_tests++;
    if (count !== (AW+1)'(exp_q.size())) begin n_fail++; $display("FAIL %s count: got %0d exp %0d", name, count, exp_q.size()); end
    n_tests++;
    if (cnt_wet - w0 != exp_wet || cnt_fit - f0 != exp_fit) begin
      n_fail++; $display("FAIL %s strobes: weT %0d fit %0d exp %0d/%0d", name, cnt_wet - w0, cnt_fit - f0, exp_wet, exp_fit);
    end
    n_tests++;
    if (eh_hist[0] !== 1'b0 || (exp_wet == 2 && eh_hist[1] !== 1'b1)) begin
      n_fail++; $display("FAIL %s eh_order: got %b exp %s", name, eh_hist[1:0], (exp_wet == 2) ? "10" : "x0");
    end
    n_tests++;
    if (wet_tipo !== t) begin n_fail++; $display("FAIL %s tipo: got %0d exp %0d", name, wet_tipo, t); end
    if (ins >= 0) begin
      n_tests++;
      if (fit_addr !== 4'(ins)) begin n_fail++; $display("FAIL %s fit_addr: got %0d exp %0d", name, fit_addr, ins); end
    end
    n_tests++;
    if (!ram_matches()) begin n_fail++; $display("FAIL %s order: ram_n %0d exp %0d entries", name, ram_n, exp_q.size()); end

    if (pop_late) begin
      void'(exp_q.pop_front());
      repeat (4) @(negedge clk);
      n_tests++;
      if (cnt_shift - s0 != 1) begin n_fail++; $display("FAIL %s held_pop: shifts %0d exp 1", name, cnt_shift - s0); end
      n_tests++;
      if (count !== (AW+1)'(exp_q.size())) begin n_fail++; $display("FAIL %s held_pop_count: got %0d exp %0d", name, count, exp_q.size()); end
      n_tests++;
      if (!ram_matches()) begin n_fail++; $display("FAIL %s held_pop_order: ram_n %0d exp %0d", name, ram_n, exp_q.size()); end
    end
  endtask

  task automatic test_full();
    int strobes0, busy_seen;
    test_clear("full_pre");
    while (exp_q.size() <= DEPTH - 2)
      test_request(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'b0, "fill");
    n_tests++;
    if (full !== (exp_q.size() == DEPTH) || req_ready !== 1'b0) begin
      n_fail++; $display("FAIL full_flag: full %0b ready %0b count %0d exp size %0d ready 0", full, req_ready, count, exp_q.size());
    end
    if (exp_q.size() == DEPTH) test_pop("full_pop");
    strobes0 = cnt_wet + cnt_fit + cnt_shift + cnt_clr;
    busy_seen = 0;
    req_valid = 1'b1; req_origem = 2'd1; req_destino = 2'd2;
    repeat (6) begin
      @(negedge clk);
      if (busy === 1'b1 || req_ready !== 1'b0) busy_seen++;
    end
    req_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (busy_seen != 0 || cnt_wet + cnt_fit + cnt_shift + cnt_clr != strobes0) begin
      n_fail++; $display("FAIL near_full_block: busy/ready cycles %0d strobes %0d exp 0/0", busy_seen,
                         cnt_wet + cnt_fit + cnt_shift + cnt_clr - strobes0);
    end
    n_tests++;
    if (count !== (AW+1)'(exp_q.size())) begin n_fail++; $display("FAIL near_full_count: got %0d exp %0d", count, exp_q.size()); end
    test_clear("full_clear");
  endtask

  task automatic test_reset_mid_scan();
    bit ok;
    test_clear("rst_pre");
    repeat (3) test_request(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'b0, "rst_fill");
    wait_ready(ok);
    req_valid = 1'b1; req_origem = 2'($urandom_range(0, 3)); req_destino = 2'd0;
    @(negedge clk);
    req_valid = 1'b0;
    n_tests++;
    if (dbg_state !== SCAN) begin n_fail++; $display("FAIL rst_in_scan: state %0d exp %0d", dbg_state, SCAN); end
    reset = 1'b0;
    #1;
    n_tests++;
    if (req_ready !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_async: ready %0b busy %0b exp 0/0", req_ready, busy);
    end
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    n_tests++;
    if (dbg_state !== IDLE || count !== '0 || {ram_weT, ram_shift, ram_fit, ram_clear} !== 4'b0) begin
      n_fail++; $display("FAIL rst_release: state %0d count %0d strobes %b exp 0/0/0000", dbg_state, count,
                         {ram_weT, ram_shift, ram_fit, ram_clear});
    end
    test_clear("rst_post");
  endtask

  task automatic test_random(input int iters);
    for (int i = 0; i < iters; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 2 || exp_q.size() > DEPTH - 2) test_pop("rnd_pop");
      else if (r == 9) test_clear("rnd_clr");
      else test_request(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                        ($urandom_range(0, 5) == 0), "rnd_req");
    end
  endtask

  initial begin
    test_reset();
    test_clear("init_clear");
    test_request(2'd2, 2'd2, 2'd3, 1'b0, "empty_req");
    test_clear("c1");
    test_request(2'd1, 2'd0, 2'd3, 1'b0, "q03");
    test_request(2'd0, 2'd1, 2'd2, 1'b0, "fit_mid");
    test_clear("c2");
    test_request(2'd0, 2'd1, 2'd2, 1'b0, "q12");
    test_request(2'd3, 2'd3, 2'd0, 1'b0, "no_hit");
    test_request(2'd2, 2'd0, 2'd1, 1'b1, "pend_pop");
    test_clear("c3");
    test_pop("pop_empty");
`ifdef FILA_DEDUP_EN
    test_request(2'd1, 2'd2, 2'd0, 1'b0, "dedup_pre");
    test_request(2'd0, 2'd2, 2'd1, 1'b0, "dedup_hit");
    test_clear("c4");
`endif
    test_full();
    test_reset_mid_scan();
    test_random(60);
    n_tests++;
    if (excl_err != 0) begin n_fail++; $display("FAIL strobe_exclusive: overlapping cycles %0d exp 0", excl_err); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fila_scheduler.md
Name: fila_scheduler

Overview:
- Sequencer for the 16-entry stop queue RAM (sync_ram_16x4_mod) in SmartCargo.
- Accepts transport requests (type, origin floor, destination floor) and serves pop/clear commands from the main cargo FSM.
- For each request it drives weT, fit, shift and clear on the RAM, and the secondary read addresses.
- Inserts the origin stop mid-route when it lies between two queued stops; otherwise appends it. The destination stop is always appended.

Parameters:
- DEPTH, 16, queue entries; must match the RAM.
- AW, 4, address width, equal to log2(DEPTH).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request offered.
- req_ready  out  1  scheduler can accept a request; high only in IDLE with count <= DEPTH-2.
- req_tipo  in  2  object type.
- req_origem  in  2  origin floor.
- req_destino  in  2  destination floor.
- pop  in  1  head stop served; 1-cycle pulse.
- clear_all  in  1  flush the queue.
- busy  out  1  FSM not in IDLE.
- count  out  AW+1  valid entries, 0..DEPTH.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- ram_weT, ram_shift, ram_fit, ram_clear  out  1 each  RAM strobes; 1-cycle pulses, mutually exclusive.
- ram_addr_sec, ram_addr_sec_ant  out  AW each  scan addresses.
- ram_in_eh_origem  out  1  RAM write field.
- ram_in_tipo  out  2  RAM write field.
- ram_in_origem  out  2  RAM write field.
- ram_in_destino  out  2  RAM write field.
- ram_saida_sec, ram_saida_sec_ant  in  2 each  floor of stop at addr_sec and at addr_sec_ant; combinational from the RAM.

Behaviour:
- Reset (async, active-low):
  - State goes to IDLE; count=0; all strobes 0; addresses 0; write fields 0; req_ready=0 while reset is asserted.
  - Reset during any operation abandons it. RAM contents are not cleared by reset; a clear_all is needed for that.
- Request handshake:
  - A request is accepted when req_valid && req_ready at a rising edge.
  - Fields are latched into req_q on acceptance.
- Priority in IDLE: clear_all > pop > request.
  - A pop that arrives while not in IDLE is held in one pending flag and served on return to IDLE.
  - A second pop while the flag is already set is dropped.
- IDLE -> CLEAR: pulse ram_clear, count<=0, return to IDLE. clear_all also clears the pending-pop flag.
- IDLE -> POP:
  - If count>0: pulse ram_shift, count-1.
  - If count==0: no strobe, count unchanged.
  - Return to IDLE.
- IDLE -> SCAN (on an accepted request): k<=1; drive addr_sec_ant=k-1 and addr_sec=k.
- SCAN:
  - Each cycle, compare prev=ram_saida_sec_ant and cur=ram_saida_sec against origem.
  - Hit when min(prev,cur) < origem < max(prev,cur), strict.
  - Hit -> FIT with ins=k.
  - No hit -> k+1. When k reaches count (or count<2) -> APPEND_ORIG.
  - Scan cost: max(1, count-1) cycles.
- FIT:
  - Pulse ram_fit with addr_sec=ins and fields {eh_origem=1, tipo, origem, destino}; count+1.
  - Then -> APPEND_DEST.
- APPEND_ORIG: pulse ram_weT with eh_origem=1; count+1; then -> APPEND_DEST.
- APPEND_DEST: pulse ram_weT with eh_origem=0 and the same fields; count+1; then -> IDLE.
- Every request adds exactly 2 entries. req_ready requires count <= DEPTH-2, so count never exceeds DEPTH.
- Latency, accept to IDLE: scan cycles + 2.
- The scan never runs past count-1. Addresses saturate and never wrap.
- Outputs empty, full and count are registered-state derived and update the cycle after the strobe.

Optional Feature:
- Macro: FILA_DEDUP_EN.
- Defined:
  - SCAN also flags a match when cur==origem or prev==origem.
  - On a match, the origin entry is skipped (no fit, no weT); only the destination is appended, so count+1.
  - req_ready still requires 2 free entries.
- Undefined: duplicate floors are queued normally.

Decomposition:
- Package fila_pkg:
  - FSM state enum: IDLE, CLEAR, POP, SCAN, FIT, APPEND_ORIG, APPEND_DEST.
  - Entry field widths (tipo/floor = 2).
  - DEPTH/AW defaults.
- Sub-module fila_between_cmp: combinational strict-between and equality check (prev, cur, floor -> hit, eq). Reused by the scan and by the dedup path.

Test Plan:
- Reset low mid-SCAN, then release -> state IDLE, count=0, all strobes 0 in the next cycle.
- Empty queue, request {tipo=2, origem=2, destino=3} -> one ram_weT with eh_origem=1, then one with eh_origem=0; count=2; busy for 3 cycles.
- Queue stops [0,3] (count=2), request origem=1, destino=2 -> ram_fit at addr_sec=1, then weT; count=4; resulting order 0,1,3,2.
- Queue stops [1,2], request origem=3 -> no hit, two weT pulses; count=4.
- pop pulsed during APPEND_DEST -> exactly one ram_shift in the first IDLE cycle, count-1; pop with count=0 -> no ram_shift.
- count=15 -> req_ready=0 and no strobes despite req_valid; clear_all -> ram_clear and count=0. With FILA_DEDUP_EN, queue [2,0] and origem=2 -> single weT, count=3.
